// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, bus FSM state codes and byte-lane helper for the AHB slave RAM.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [1:0] HRESP_OKAY  = 2'd0;
    localparam logic [1:0] HRESP_ERROR = 2'd1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef logic [1:0] ahb_state_t;
    localparam ahb_state_t ST_IDLE = 2'd0;
    localparam ahb_state_t ST_WAIT = 2'd1;
    localparam ahb_state_t ST_ERR1 = 2'd2;
    localparam ahb_state_t ST_ERR2 = 2'd3;

    // Little-endian lane enables; only meaningful for legal (aligned, <= word) transfers.
    function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << off;
            HSIZE_HALF: strb = 4'b0011 << off;
            default:    strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/ahb_sram_core.sv
// Single-port synchronous SRAM with per-byte write enables and a registered read port.
module ahb_sram_core #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 32
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // A cycle with no lane enables is a read.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            if (we_i == 4'b0000) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_slave_ram.sv
// AHB-Lite slave in front of a byte-writable SRAM: bus FSM, error decode, wait states and a
// pending-write bypass so a write followed directly by a read shares the single RAM port.
module ahb_slave_ram
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int unsigned IDX_W     = ADDR_WIDTH - 2;
    localparam int unsigned RAM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

    ahb_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  dp_valid_q, dp_valid_d;
    logic                  dp_write_q, dp_write_d;
    logic [RAM_AW-1:0]     dp_addr_q, dp_addr_d;
    logic [3:0]            dp_strb_q, dp_strb_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [RAM_AW-1:0]     pend_addr_q, pend_addr_d;
    logic [3:0]            pend_strb_q, pend_strb_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [3:0]            byp_strb_q, byp_strb_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    logic [IDX_W-1:0]      a_idx;
    logic [RAM_AW-1:0]     a_ram_addr;
    logic                  a_misalign, a_err, accept, ready;
    logic                  wr_done, rd_issue;
    logic [RAM_AW-1:0]     rd_addr;
    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [RAM_AW-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata, rd_merged;
    logic                  unused_bits;

    assign unused_bits = ^{hburst, htrans[0]};

    assign a_idx      = haddr[ADDR_WIDTH-1:2];
    assign a_ram_addr = haddr[RAM_AW+1:2];

    always_comb begin
        a_misalign = 1'b0;
        if (hsize == HSIZE_HALF) a_misalign = haddr[0];
        if (hsize == HSIZE_WORD) a_misalign = |haddr[1:0];
    end

    assign a_err  = (a_idx >= IDX_W'(MEM_DEPTH)) | (hsize > HSIZE_WORD) | a_misalign;
    assign ready  = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign accept = hsel & hready & htrans[1] & ready;

    assign hreadyout = ready;
    assign hresp     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept && a_err) begin
                    state_d = ST_ERR1;
                end else if (accept && !ZERO_WAIT) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_IDLE;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // Errored transfers never become a valid data phase, so they never touch the RAM.
    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        dp_strb_d  = dp_strb_q;
        if (ready) begin
            dp_valid_d = accept & ~a_err;
            if (accept) begin
                dp_write_d = hwrite;
                dp_addr_d  = a_ram_addr;
                dp_strb_d  = byte_strobe(hsize, haddr[1:0]);
            end
        end
    end

    assign wr_done = ready & dp_valid_q & dp_write_q;

    always_comb begin
        if (ZERO_WAIT) begin
            rd_issue = accept & ~a_err & ~hwrite;
            rd_addr  = a_ram_addr;
        end else begin
            rd_issue = (state_q == ST_WAIT) & (cnt_q == 4'd1) & dp_valid_q & ~dp_write_q;
            rd_addr  = dp_addr_q;
        end
    end

    // Reads own the port; a write that collides with one parks in the pending register and
    // is committed on the next free cycle, with reads to that word merged from it meanwhile.
    always_comb begin
        ram_en       = 1'b0;
        ram_we       = 4'b0000;
        ram_addr     = rd_addr;
        ram_wdata    = hwdata;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_strb_d  = pend_strb_q;
        pend_data_d  = pend_data_q;
        byp_strb_d   = byp_strb_q;
        byp_data_d   = byp_data_q;
        if (rd_issue) begin
            ram_en = 1'b1;
            if (wr_done && dp_addr_q == rd_addr) begin
                byp_strb_d = dp_strb_q;
                byp_data_d = hwdata;
            end else if (pend_valid_q && pend_addr_q == rd_addr) begin
                byp_strb_d = pend_strb_q;
                byp_data_d = pend_data_q;
            end else begin
                byp_strb_d = 4'b0000;
            end
            if (wr_done) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = dp_addr_q;
                pend_strb_d  = dp_strb_q;
                pend_data_d  = hwdata;
            end
        end else if (pend_valid_q) begin
            ram_en       = 1'b1;
            ram_we       = pend_strb_q;
            ram_addr     = pend_addr_q;
            ram_wdata    = pend_data_q;
            pend_valid_d = wr_done;
            if (wr_done) begin
                pend_addr_d = dp_addr_q;
                pend_strb_d = dp_strb_q;
                pend_data_d = hwdata;
            end
        end else if (wr_done) begin
            ram_en    = 1'b1;
            ram_we    = dp_strb_q;
            ram_addr  = dp_addr_q;
            ram_wdata = hwdata;
        end
    end

    assign rd_valid_d = rd_issue;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_merged[8*i +: 8] = byp_strb_q[i] ? byp_data_q[8*i +: 8] : ram_rdata[8*i +: 8];
        end
        hrdata_d = rd_valid_q ? rd_merged : hrdata_q;
    end

    assign hrdata = hrdata_d;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            dp_valid_q   <= 1'b0;
            dp_write_q   <= 1'b0;
            dp_addr_q    <= '0;
            dp_strb_q    <= 4'b0000;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_strb_q  <= 4'b0000;
            pend_data_q  <= '0;
            rd_valid_q   <= 1'b0;
            byp_strb_q   <= 4'b0000;
            byp_data_q   <= '0;
            hrdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dp_valid_q   <= dp_valid_d;
            dp_write_q   <= dp_write_d;
            dp_addr_q    <= dp_addr_d;
            dp_strb_q    <= dp_strb_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_strb_q  <= pend_strb_d;
            pend_data_q  <= pend_data_d;
            rd_valid_q   <= rd_valid_d;
            byp_strb_q   <= byp_strb_d;
            byp_data_q   <= byp_data_d;
            hrdata_q     <= hrdata_d;
        end
    end

    ahb_sram_core #(
        .DEPTH (MEM_DEPTH),
        .AW    (RAM_AW),
        .DW    (DATA_WIDTH)
    ) u_core (
        .clk_i   (hclk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_ahb_slave_ram.sv
// Directed bench: a zero-wait slave and a two-wait-state slave share one driven bus.
module tb_ahb_slave_ram;
    import ahb_pkg::*;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        sel, use_w2;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;

    logic        hsel0, hsel2, hro0, hro2, hready_b;
    logic [1:0]  hresp0, hresp2, hresp_b;
    logic [31:0] hrdata0, hrdata2, hrdata_b;

    int errors = 0;
    int checks = 0;

    always #5 hclk = ~hclk;

    assign hsel0    = sel & ~use_w2;
    assign hsel2    = sel & use_w2;
    assign hready_b = use_w2 ? hro2 : hro0;
    assign hresp_b  = use_w2 ? hresp2 : hresp0;
    assign hrdata_b = use_w2 ? hrdata2 : hrdata0;

    ahb_slave_ram #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_DEPTH (1024), .WAIT_STATES (0)
    ) u_dut0 (
        .hclk (hclk), .hresetn (hresetn), .hsel (hsel0), .haddr (haddr), .htrans (htrans),
        .hwrite (hwrite), .hsize (hsize), .hburst (hburst), .hwdata (hwdata),
        .hready (hready_b), .hreadyout (hro0), .hresp (hresp0), .hrdata (hrdata0)
    );

    ahb_slave_ram #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_DEPTH (4096), .WAIT_STATES (2)
    ) u_dut2 (
        .hclk (hclk), .hresetn (hresetn), .hsel (hsel2), .haddr (haddr), .htrans (htrans),
        .hwrite (hwrite), .hsize (hsize), .hburst (hburst), .hwdata (hwdata),
        .hready (hready_b), .hreadyout (hro2), .hresp (hresp2), .hrdata (hrdata2)
    );

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [2:0] bu);
        sel    = 1'b1;
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hburst = bu;
    endtask

    task automatic wait_ready(output int waits);
        waits = 0;
        while (hready_b !== 1'b1 && waits < 20) begin
            step();
            waits++;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                            output int waits);
        addr_phase(HTRANS_NONSEQ, 1'b1, a, sz, HBURST_SINGLE);
        step();
        htrans = HTRANS_IDLE;
        hwdata = d;
        wait_ready(waits);
        step();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] d,
                           output int waits);
        addr_phase(HTRANS_NONSEQ, 1'b0, a, sz, HBURST_SINGLE);
        step();
        htrans = HTRANS_IDLE;
        wait_ready(waits);
        d = hrdata_b;
        step();
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        sel = 1'b0; use_w2 = 1'b0; haddr = '0; hwdata = '0;
        htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = HSIZE_WORD; hburst = HBURST_SINGLE;
        #12;
        checks++; if (hro0 !== 1'b1) begin errors++;
            $display("FAIL reset_hreadyout0: got %b expected 1", hro0); end
        checks++; if (hresp0 !== HRESP_OKAY) begin errors++;
            $display("FAIL reset_hresp0: got %0d expected 0", hresp0); end
        checks++; if (hrdata0 !== 32'h0) begin errors++;
            $display("FAIL reset_hrdata0: got %h expected 0", hrdata0); end
        checks++; if (hro2 !== 1'b1 || hresp2 !== HRESP_OKAY || hrdata2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_dut2: got ro=%b resp=%0d rd=%h expected 1 0 0",
                     hro2, hresp2, hrdata2); end
        @(negedge hclk);
        hresetn = 1'b1;
        step();
    endtask

    task automatic test_word_rw();
        int wt;
        logic [31:0] d;
        use_w2 = 1'b0;
        do_write(32'h10, HSIZE_WORD, 32'hDEADBEEF, wt);
        checks++; if (wt !== 0) begin errors++;
            $display("FAIL word_wr_waits: got %0d expected 0", wt); end
        do_read(32'h10, HSIZE_WORD, d, wt);
        checks++; if (d !== 32'hDEADBEEF) begin errors++;
            $display("FAIL word_rd_data: got %h expected deadbeef", d); end
        checks++; if (wt !== 0) begin errors++;
            $display("FAIL word_rd_waits: got %0d expected 0", wt); end
        checks++; if (hresp_b !== HRESP_OKAY) begin errors++;
            $display("FAIL word_rd_resp: got %0d expected 0", hresp_b); end
    endtask

    task automatic test_byte_half();
        int wt;
        logic [31:0] d;
        use_w2 = 1'b0;
        do_write(32'h20, HSIZE_WORD, 32'hFFFFFFFF, wt);
        do_write(32'h22, HSIZE_BYTE, 32'h115A2233, wt);
        do_write(32'h20, HSIZE_HALF, 32'hAABB1234, wt);
        do_read(32'h20, HSIZE_WORD, d, wt);
        checks++; if (d !== 32'hFF5A1234) begin errors++;
            $display("FAIL byte_half_merge: got %h expected ff5a1234", d); end
    endtask

    task automatic test_back_to_back();
        int wt;
        logic [31:0] d;
        use_w2 = 1'b0;
        // Full-word write then read of the same word in consecutive address phases.
        addr_phase(HTRANS_NONSEQ, 1'b1, 32'h30, HSIZE_WORD, HBURST_SINGLE);
        step();
        hwdata = 32'hCAFEF00D;
        addr_phase(HTRANS_NONSEQ, 1'b0, 32'h30, HSIZE_WORD, HBURST_SINGLE);
        step();
        htrans = HTRANS_IDLE;
        checks++; if (hrdata_b !== 32'hCAFEF00D || hready_b !== 1'b1) begin errors++;
            $display("FAIL b2b_full: got %h ro=%b expected cafef00d ro=1", hrdata_b, hready_b);
        end
        step();
        // Byte write merged with old bytes of the same word.
        do_write(32'h34, HSIZE_WORD, 32'h11223344, wt);
        addr_phase(HTRANS_NONSEQ, 1'b1, 32'h35, HSIZE_BYTE, HBURST_SINGLE);
        step();
        hwdata = 32'h0000AB00;
        addr_phase(HTRANS_NONSEQ, 1'b0, 32'h34, HSIZE_WORD, HBURST_SINGLE);
        step();
        htrans = HTRANS_IDLE;
        checks++; if (hrdata_b !== 32'h1122AB44) begin errors++;
            $display("FAIL b2b_partial: got %h expected 1122ab44", hrdata_b); end
        step();
        do_read(32'h34, HSIZE_WORD, d, wt);
        checks++; if (d !== 32'h1122AB44) begin errors++;
            $display("FAIL b2b_partial_commit: got %h expected 1122ab44", d); end
        // Write then read of a different word; the write must still land.
        addr_phase(HTRANS_NONSEQ, 1'b1, 32'h38, HSIZE_WORD, HBURST_SINGLE);
        step();
        hwdata = 32'h00000055;
        addr_phase(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, HBURST_SINGLE);
        step();
        htrans = HTRANS_IDLE;
        checks++; if (hrdata_b !== 32'hDEADBEEF) begin errors++;
            $display("FAIL b2b_other_rd: got %h expected deadbeef", hrdata_b); end
        step();
        do_read(32'h38, HSIZE_WORD, d, wt);
        checks++; if (d !== 32'h00000055) begin errors++;
            $display("FAIL b2b_other_commit: got %h expected 00000055", d); end
    endtask

    task automatic test_errors();
        int wt;
        logic [31:0] d;
        use_w2 = 1'b0;
        addr_phase(HTRANS_NONSEQ, 1'b0, 32'h1000, HSIZE_WORD, HBURST_SINGLE);
        step();
        htrans = HTRANS_IDLE;
        checks++; if (hready_b !== 1'b0 || hresp_b !== HRESP_ERROR) begin errors++;
            $display("FAIL oob_err1: got ro=%b resp=%0d expected 0 1", hready_b, hresp_b); end
        step();
        checks++; if (hready_b !== 1'b1 || hresp_b !== HRESP_ERROR) begin errors++;
            $display("FAIL oob_err2: got ro=%b resp=%0d expected 1 1", hready_b, hresp_b); end
        checks++; if (hrdata_b !== 32'h00000055) begin errors++;
            $display("FAIL oob_hrdata_hold: got %h expected 00000055", hrdata_b); end
        step();
        checks++; if (hresp_b !== HRESP_OKAY || hready_b !== 1'b1) begin errors++;
            $display("FAIL oob_after: got ro=%b resp=%0d expected 1 0", hready_b, hresp_b); end
        do_write(32'h40, HSIZE_WORD, 32'h0BADF00D, wt);
        addr_phase(HTRANS_NONSEQ, 1'b1, 32'h41, HSIZE_HALF, HBURST_SINGLE);
        step();
        htrans = HTRANS_IDLE;
        hwdata = 32'h99999999;
        checks++; if (hready_b !== 1'b0 || hresp_b !== HRESP_ERROR) begin errors++;
            $display("FAIL mis_err1: got ro=%b resp=%0d expected 0 1", hready_b, hresp_b); end
        step();
        checks++; if (hready_b !== 1'b1 || hresp_b !== HRESP_ERROR) begin errors++;
            $display("FAIL mis_err2: got ro=%b resp=%0d expected 1 1", hready_b, hresp_b); end
        step();
        do_read(32'h40, HSIZE_WORD, d, wt);
        checks++; if (d !== 32'h0BADF00D) begin errors++;
            $display("FAIL mis_sram_unchanged: got %h expected 0badf00d", d); end
        addr_phase(HTRANS_NONSEQ, 1'b0, 32'h10, 3'd3, HBURST_SINGLE);
        step();
        htrans = HTRANS_IDLE;
        checks++; if (hready_b !== 1'b0 || hresp_b !== HRESP_ERROR) begin errors++;
            $display("FAIL size_err1: got ro=%b resp=%0d expected 0 1", hready_b, hresp_b); end
        step();
        step();
    endtask

    task automatic test_wait_states();
        int wt;
        use_w2 = 1'b1;
        addr_phase(HTRANS_NONSEQ, 1'b1, 32'h2000, HSIZE_WORD, HBURST_INCR4);
        step();
        for (int i = 0; i < 4; i++) begin
            hwdata = 32'hFACEFEE0 + 32'(i);
            if (i < 3) addr_phase(HTRANS_SEQ, 1'b1, 32'h2000 + 32'(4 * (i + 1)), HSIZE_WORD,
                                  HBURST_INCR4);
            else htrans = HTRANS_IDLE;
            wait_ready(wt);
            checks++; if (wt !== 2) begin errors++;
                $display("FAIL ws_wr_beat%0d_waits: got %0d expected 2", i, wt); end
            step();
        end
        addr_phase(HTRANS_NONSEQ, 1'b0, 32'h2000, HSIZE_WORD, HBURST_INCR4);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) addr_phase(HTRANS_BUSY, 1'b0, 32'h2008, HSIZE_WORD, HBURST_INCR4);
            else if (i < 3) addr_phase(HTRANS_SEQ, 1'b0, 32'h2000 + 32'(4 * (i + 1)),
                                       HSIZE_WORD, HBURST_INCR4);
            else htrans = HTRANS_IDLE;
            wait_ready(wt);
            checks++; if (wt !== 2 || hrdata_b !== 32'hFACEFEE0 + 32'(i)) begin errors++;
                $display("FAIL ws_rd_beat%0d: got waits=%0d data=%h expected 2 %h",
                         i, wt, hrdata_b, 32'hFACEFEE0 + 32'(i)); end
            step();
            if (i == 1) begin
                checks++; if (hready_b !== 1'b1 || hresp_b !== HRESP_OKAY) begin errors++;
                    $display("FAIL ws_busy: got ro=%b resp=%0d expected 1 0",
                             hready_b, hresp_b); end
                addr_phase(HTRANS_SEQ, 1'b0, 32'h2008, HSIZE_WORD, HBURST_INCR4);
                step();
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int wt;
        logic [31:0] d;
        use_w2 = 1'b1;
        addr_phase(HTRANS_NONSEQ, 1'b0, 32'h2004, HSIZE_WORD, HBURST_SINGLE);
        step();
        htrans = HTRANS_IDLE;
        checks++; if (hro2 !== 1'b0) begin errors++;
            $display("FAIL rst_pre_wait: got ro=%b expected 0", hro2); end
        #2;
        hresetn = 1'b0;
        #1;
        checks++; if (hro2 !== 1'b1 || hresp2 !== HRESP_OKAY || hrdata2 !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: got ro=%b resp=%0d rd=%h expected 1 0 0",
                     hro2, hresp2, hrdata2); end
        @(negedge hclk);
        hresetn = 1'b1;
        step();
        do_read(32'h2004, HSIZE_WORD, d, wt);
        checks++; if (d !== 32'hFACEFEE1 || wt !== 2) begin errors++;
            $display("FAIL rst_after_read: got %h waits=%0d expected facefee1 2", d, wt); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_back_to_back();
        test_errors();
        test_wait_states();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d",
                 errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/ahb_slave_ram.md
Name: ahb_slave_ram

Overview:
AHB-Lite slave fronting a word-organised, byte-writable on-chip SRAM. It is the responder end of the bus that the team's ahb_master drives. It accepts single and burst transfers, and supports programmable wait states. It issues the two-cycle ERROR response for illegal accesses. It sits behind the address decoder, which drives hsel.

Parameters:
ADDR_WIDTH, 32, width of haddr
DATA_WIDTH, 32, width of hwdata/hrdata; fixed at 32 in this revision
MEM_DEPTH, 1024, number of DATA_WIDTH words; word index = haddr[ADDR_WIDTH-1:2]
WAIT_STATES, 0, extra data-phase cycles inserted per accepted transfer (0..15)

Ports:
hclk  in  1  bus clock; all state on rising edge
hresetn  in  1  asynchronous active-low reset
hsel  in  1  slave select from decoder
haddr  in  ADDR_WIDTH  byte address (address phase)
htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
hwrite  in  1  1 write, 0 read
hsize  in  3  0 byte, 1 half, 2 word; larger values are illegal
hburst  in  3  burst type; informational only, not checked
hwdata  in  DATA_WIDTH  write data (data phase)
hready  in  1  bus-level HREADY (previous data phase complete)
hreadyout  out  1  this slave's ready
hresp  out  2  0 OKAY, 1 ERROR
hrdata  out  DATA_WIDTH  read data, valid when hreadyout=1 in a read data phase

Behaviour:
- Reset (asynchronous, hresetn=0):
  - Outputs: hreadyout=1, hresp=OKAY, hrdata=0.
  - State: FSM to ST_IDLE, wait counter=0, pending-write valid=0.
  - SRAM contents are not reset.
- Accept condition: hsel & hready & htrans[1]. On accept, register addr, hwrite, hsize and the error flag into the data-phase registers. IDLE/BUSY or hsel=0 clear the data-phase valid flag; the response is OKAY, zero-wait.
- Error flag, any of the following:
  - word index >= MEM_DEPTH
  - hsize > 2
  - misaligned: haddr & ((1<<hsize)-1) != 0
- FSM states: ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2.
  - ST_IDLE: hreadyout=1, hresp=OKAY.
    - Accept with error -> ST_ERR1.
    - Accept with WAIT_STATES>0 -> ST_WAIT, counter=WAIT_STATES.
    - Otherwise stay in ST_IDLE.
  - ST_WAIT: hreadyout=0, hresp=OKAY. Counter decrements each cycle. At counter=1, go to ST_IDLE (the completing cycle). No new accept is possible while hreadyout=0.
  - ST_ERR1: hreadyout=0, hresp=ERROR -> ST_ERR2.
  - ST_ERR2: hreadyout=1, hresp=ERROR.
    - Accept with error -> ST_ERR1.
    - Accept with WAIT_STATES>0 -> ST_WAIT.
    - Otherwise -> ST_IDLE.
  - An errored transfer never reads or writes the SRAM. hrdata holds its previous value.
- Byte lanes (little-endian), from latched addr[1:0] and hsize:
  - byte: strobe 1<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Write: hwdata is sampled on the edge that completes the data phase (hreadyout=1). Only strobed lanes are written. Latency: visible to a read whose address phase is accepted on or after that edge.
- Read: the SRAM word is captured at the completing edge of the address phase (zero-wait) or the last wait edge. hrdata presents the full word; the master selects lanes.
- Hazard: a read accepted on the same edge a write to the same word completes returns merged data. That is new bytes on strobed lanes and old bytes elsewhere. A pending-write bypass register implements this.
- Reset mid-transfer: all state aborts immediately. A partially completed write is not committed unless its completing edge preceded reset assertion.
- Bursts: each beat is decoded independently from haddr. SEQ, NONSEQ and BUSY within a burst need no special handling.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/ERROR
  - HSIZE_BYTE/HALF/WORD
  - HBURST_SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16
  - the FSM state enum
- One sub-module: ahb_sram_core, a single-port synchronous RAM with 4-bit byte-write enable and registered read. The top level holds the bus FSM, error decode, wait counter and bypass.

Test Plan:
- Word write then read: NONSEQ write 0x0000_0010 = 0xDEADBEEF, then NONSEQ read 0x0000_0010 -> hrdata=0xDEADBEEF, hresp=OKAY, hreadyout never low (WAIT_STATES=0).
- Byte/half writes: word 0x20 preset to 0xFFFFFFFF; write byte 0x22 with hwdata lane2=0x5A, then half 0x20 = 0x1234 -> read 0x20 returns 0xFF5A1234.
- Back-to-back hazard: write 0x30=0xCAFEF00D immediately followed by a read of 0x30 in the next address phase -> hrdata=0xCAFEF00D.
- Errors: word read at 0x0000_1000 (index 1024) -> hreadyout 0 then 1 with hresp=ERROR both cycles, SRAM unchanged. Misaligned half at 0x41 gives the same response.
- Wait states (WAIT_STATES=2): INCR4 write 0x2000..0x200C data 0xFACEFEE0+i -> each beat shows hreadyout low 2 cycles; readback matches. A BUSY inserted mid-burst gives an OKAY zero-wait response.
- Reset mid-wait: assert hresetn=0 during ST_WAIT -> hreadyout=1, hresp=OKAY and hrdata=0 immediately (asynchronously). The subsequent transfer behaves normally.
